// File: rtl/apb_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : apb_spi_pkg
// Brief  : Shared FSM state encoding and timeout default for the APB master.
// Rev    : 1.0
// ============================================================================
package apb_spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int C_TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : apb_rr_arbiter2
// Brief  : Two-way round-robin grant; on a tie the non-owner wins.
// Rev    : 1.0
// ============================================================================
module apb_rr_arbiter2
   import apb_spi_pkg::*;
(
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_owner,
   output logic o_grant,
   output logic o_any
);

   assign o_any   = i_valid0 | i_valid1;
   assign o_grant = (i_valid0 & i_valid1) ? ~i_owner : i_valid1;

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module : apb_master_arbiter
// Brief  : APB master shared by two requesters with round-robin arbitration
//          and an ACCESS-phase timeout.
// Rev    : 1.0
// ============================================================================
module apb_master_arbiter
   import apb_spi_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_DEFAULT
) (
   input  logic                      apb_pclk_i,
   input  logic                      apb_preset_ni,
   input  logic                      req0_valid_i,
   input  logic [APB_ADDR_WIDTH-1:0] req0_addr_i,
   input  logic                      req0_write_i,
   input  logic [APB_DATA_WIDTH-1:0] req0_wdata_i,
   output logic                      req0_done_o,
   output logic [APB_DATA_WIDTH-1:0] req0_rdata_o,
   output logic                      req0_err_o,
   input  logic                      req1_valid_i,
   input  logic [APB_ADDR_WIDTH-1:0] req1_addr_i,
   input  logic                      req1_write_i,
   input  logic [APB_DATA_WIDTH-1:0] req1_wdata_i,
   output logic                      req1_done_o,
   output logic [APB_DATA_WIDTH-1:0] req1_rdata_o,
   output logic                      req1_err_o,
   output logic                      apb_psel_o,
   output logic                      apb_penable_o,
   output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
   output logic                      apb_pwrite_o,
   output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
   input  logic                      apb_pready_i,
   output logic                      owner_o
);

   localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   apb_state_t                r_state;
   apb_state_t                w_state_nxt;
   logic                      r_psel;
   logic                      r_penable;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic                      r_pwrite;
   logic [APB_DATA_WIDTH-1:0] r_pwdata;
   logic                      r_owner;
   logic [15:0]               r_cnt;
   logic                      r_done0;
   logic                      r_done1;
   logic                      r_err0;
   logic                      r_err1;
   logic [APB_DATA_WIDTH-1:0] r_rdata0;
   logic [APB_DATA_WIDTH-1:0] r_rdata1;

   logic                      w_grant;
   logic                      w_any;
   logic                      w_start;
   logic                      w_complete;
   logic                      w_timeout;
   logic                      w_finish;
   logic [APB_DATA_WIDTH-1:0] w_rdata_cap;

   apb_rr_arbiter2 u_arb (
      .i_valid0 (req0_valid_i),
      .i_valid1 (req1_valid_i),
      .i_owner  (r_owner),
      .o_grant  (w_grant),
      .o_any    (w_any)
   );

   // Requests are ignored in the done cycle, forcing one IDLE gap between transfers.
   assign w_start     = (r_state == IDLE) && w_any && !(r_done0 || r_done1);
   assign w_complete  = (r_state == ACCESS) && apb_pready_i;
   assign w_timeout   = (r_state == ACCESS) && !apb_pready_i && (r_cnt == C_TO_LAST);
   assign w_finish    = w_complete || w_timeout;
   assign w_rdata_cap = (w_complete && !r_pwrite) ? apb_prdata_i : '0;

   always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
      if (!apb_preset_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (w_finish) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
      if (!apb_preset_ni) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_owner   <= 1'b1;
         r_cnt     <= '0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_psel    <= (w_state_nxt != IDLE);
         r_penable <= (w_state_nxt == ACCESS);
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_cnt     <= ((r_state == ACCESS) && (w_state_nxt == ACCESS)) ? r_cnt + 16'd1 : '0;
         if (w_start) begin
            r_owner  <= w_grant;
            r_paddr  <= w_grant ? req1_addr_i  : req0_addr_i;
            r_pwrite <= w_grant ? req1_write_i : req0_write_i;
            r_pwdata <= w_grant ? req1_wdata_i : req0_wdata_i;
         end
         if (w_finish) begin
            if (r_owner) begin
               r_done1  <= 1'b1;
               r_err1   <= w_timeout;
               r_rdata1 <= w_rdata_cap;
            end else begin
               r_done0  <= 1'b1;
               r_err0   <= w_timeout;
               r_rdata0 <= w_rdata_cap;
            end
         end
      end
   end

   assign apb_psel_o    = r_psel;
   assign apb_penable_o = r_penable;
   assign apb_paddr_o   = r_paddr;
   assign apb_pwrite_o  = r_pwrite;
   assign apb_pwdata_o  = r_pwdata;
   assign owner_o       = r_owner;
   assign req0_done_o   = r_done0;
   assign req0_err_o    = r_err0;
   assign req0_rdata_o  = r_rdata0;
   assign req1_done_o   = r_done1;
   assign req1_err_o    = r_err1;
   assign req1_rdata_o  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_apb_master_arbiter
// Brief  : Directed scoreboard bench for apb_master_arbiter (TIMEOUT_CYCLES=4).
// Rev    : 1.0
// ============================================================================
module tb_apb_master_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_write, req0_done, req0_err;
   logic [31:0] req0_addr, req0_wdata, req0_rdata;
   logic        req1_valid, req1_write, req1_done, req1_err;
   logic [31:0] req1_addr, req1_wdata, req1_rdata;
   logic        psel, penable, pwrite, pready, owner;
   logic [31:0] paddr, pwdata, prdata;

   typedef struct {
      bit          id;
      logic [31:0] rdata;
      bit          err;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          acc_n = 0;
   int          wait_n = 0;
   bit          stuck = 0;
   int          rem0 = 0;
   int          rem1 = 0;
   int          setup_cyc = 0;
   int          done_cyc = 0;
   logic [31:0] setup_addr, setup_wdata;
   logic        setup_write;
   logic [31:0] m_rd0 = '0;
   logic [31:0] m_rd1 = '0;

   apb_master_arbiter #(
      .APB_ADDR_WIDTH (32),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .apb_pclk_i    (clk),
      .apb_preset_ni (rst_n),
      .req0_valid_i  (req0_valid),
      .req0_addr_i   (req0_addr),
      .req0_write_i  (req0_write),
      .req0_wdata_i  (req0_wdata),
      .req0_done_o   (req0_done),
      .req0_rdata_o  (req0_rdata),
      .req0_err_o    (req0_err),
      .req1_valid_i  (req1_valid),
      .req1_addr_i   (req1_addr),
      .req1_write_i  (req1_write),
      .req1_wdata_i  (req1_wdata),
      .req1_done_o   (req1_done),
      .req1_rdata_o  (req1_rdata),
      .req1_err_o    (req1_err),
      .apb_psel_o    (psel),
      .apb_penable_o (penable),
      .apb_paddr_o   (paddr),
      .apb_pwrite_o  (pwrite),
      .apb_pwdata_o  (pwdata),
      .apb_prdata_i  (prdata),
      .apb_pready_i  (pready),
      .owner_o       (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      if (a == 32'h4) return 32'h11;
      if (a == 32'h8) return 32'h22;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input bit id, input logic [31:0] rd, input bit err, input int acc);
      exp_t e;
      e.id = id; e.rdata = rd; e.err = err; e.acc = acc;
      exp_q.push_back(e);
   endtask

   task automatic check_done();
      exp_t e;
      bit   id;
      done_cyc = cyc;
      chk("done_exclusive", 64'(req0_done && req1_done), 64'd0);
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL done_unexpected: observed done0=%0b done1=%0b expected none", req0_done, req1_done);
         return;
      end
      e  = exp_q.pop_front();
      id = req1_done;
      chk("done_id", 64'(id), 64'(e.id));
      chk("rdata", 64'(id ? req1_rdata : req0_rdata), 64'(e.rdata));
      chk("err", 64'(id ? req1_err : req0_err), 64'(e.err));
      if (e.acc != 0) chk("access_cycles", 64'(acc_n), 64'(e.acc));
      chk("other_rdata_hold", 64'(id ? req0_rdata : req1_rdata), 64'(id ? m_rd0 : m_rd1));
      chk("psel_dropped", 64'(psel), 64'd0);
      if (id) begin
         m_rd1 = e.rdata;
         if (rem1 > 0) begin rem1--; if (rem1 == 0) req1_valid = 1'b0; end
      end else begin
         m_rd0 = e.rdata;
         if (rem0 > 0) begin rem0--; if (rem0 == 0) req0_valid = 1'b0; end
      end
   endtask

   // One clock; observe at the falling edge, then drive the slave for the next rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (psel && !penable) begin
         setup_cyc   = cyc;
         setup_addr  = paddr;
         setup_wdata = pwdata;
         setup_write = pwrite;
         acc_n       = 0;
      end
      if (psel && penable) acc_n++;
      if (req0_done || req1_done) check_done();
      pready = psel && penable && !stuck && (acc_n > wait_n);
      prdata = slave_data(paddr);
   endtask

   task automatic run_until_left(input int left, input int bound);
      int n = 0;
      while (exp_q.size() > left && n < bound) begin
         tick();
         n++;
      end
      if (exp_q.size() > left) begin
         tests++;
         fails++;
         $error("FAIL timeout_wait: observed %0d pending expected %0d", exp_q.size(), left);
         exp_q.delete();
      end
   endtask

   initial begin
      int d;
      int n;
      rst_n = 1'b0;
      req0_valid = 0; req0_addr = '0; req0_write = 0; req0_wdata = '0;
      req1_valid = 0; req1_addr = '0; req1_write = 0; req1_wdata = '0;
      pready = 0; prdata = '0;
      setup_addr = '0; setup_wdata = '0; setup_write = 0;
      repeat (3) tick();

      chk("rst_psel", 64'(psel), 64'd0);
      chk("rst_penable", 64'(penable), 64'd0);
      chk("rst_paddr", 64'(paddr), 64'd0);
      chk("rst_owner", 64'(owner), 64'd1);
      chk("rst_done0", 64'(req0_done), 64'd0);
      chk("rst_done1", 64'(req1_done), 64'd0);
      chk("rst_rdata0", 64'(req0_rdata), 64'd0);

      // Both requesters valid out of reset: req0 wins the first tie.
      req0_addr = 32'h4; req0_write = 0; req0_valid = 1; rem0 = 1;
      req1_addr = 32'h8; req1_write = 0; req1_valid = 1; rem1 = 1;
      push_exp(1'b0, 32'h11, 1'b0, 1);
      push_exp(1'b1, 32'h22, 1'b0, 1);
      tick();
      rst_n = 1'b1;
      run_until_left(1, 20);
      d = done_cyc;
      run_until_left(0, 20);
      chk("b2b_gap", 64'(setup_cyc - d), 64'd2);

      // Alternation: req0 for 2 transfers, req1 held for 3.
      tick();
      req0_addr = 32'h20; req0_valid = 1; rem0 = 2;
      req1_addr = 32'h30; req1_valid = 1; rem1 = 3;
      push_exp(1'b0, slave_data(32'h20), 1'b0, 1);
      push_exp(1'b1, slave_data(32'h30), 1'b0, 1);
      push_exp(1'b0, slave_data(32'h20), 1'b0, 1);
      push_exp(1'b1, slave_data(32'h30), 1'b0, 1);
      push_exp(1'b1, slave_data(32'h30), 1'b0, 1);
      run_until_left(0, 60);
      chk("alt_owner", 64'(owner), 64'd1);

      // Write with two wait states.
      tick();
      wait_n = 2;
      req0_addr = 32'h1000_0010; req0_write = 1; req0_wdata = 32'hDEAD_BEEF;
      req0_valid = 1; rem0 = 1;
      push_exp(1'b0, 32'h0, 1'b0, 3);
      run_until_left(0, 20);
      chk("wr_paddr", 64'(setup_addr), 64'h1000_0010);
      chk("wr_pwdata", 64'(setup_wdata), 64'hDEAD_BEEF);
      chk("wr_pwrite", 64'(setup_write), 64'd1);

      // Timeout with pready stuck low, then a normal transfer.
      tick();
      wait_n = 0; stuck = 1;
      req1_addr = 32'h44; req1_write = 0; req1_valid = 1; rem1 = 1;
      push_exp(1'b1, 32'h0, 1'b1, 4);
      run_until_left(0, 20);
      tick();
      stuck = 0;
      req1_addr = 32'h48; req1_valid = 1; rem1 = 1;
      push_exp(1'b1, slave_data(32'h48), 1'b0, 1);
      run_until_left(0, 20);
      tick();
      chk("idle_psel", 64'(psel), 64'd0);
      chk("idle_paddr_hold", 64'(paddr), 64'h48);

      // pready arrives in the same cycle the timeout would fire.
      wait_n = 3;
      req0_addr = 32'h50; req0_write = 0; req0_valid = 1; rem0 = 1;
      push_exp(1'b0, slave_data(32'h50), 1'b0, 4);
      run_until_left(0, 20);

      // Reset in the middle of ACCESS.
      tick();
      wait_n = 0; stuck = 1;
      req0_addr = 32'h60; req0_valid = 1; rem0 = 1;
      n = 0;
      while (!penable && n < 10) begin tick(); n++; end
      chk("pre_rst_penable", 64'(penable), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_psel", 64'(psel), 64'd0);
      chk("async_penable", 64'(penable), 64'd0);
      req0_valid = 0; rem0 = 0; stuck = 0;
      m_rd0 = '0; m_rd1 = '0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk("post_rst_owner", 64'(owner), 64'd1);
      chk("post_rst_psel", 64'(psel), 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
